beam_peak_scanner: RTL

BEAM_PEAK_SCANNER -- requirements
Module: beam_peak_scanner

---
 rtl/beam_peak_scanner_pkg.sv | 16 +
 rtl/beam_peak_update.sv | 55 +++++
 rtl/beam_peak_scanner.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/beam_peak_scanner_pkg.sv
// Shared definitions for the beam peak scanner: FSM encoding and the frame geometry
// defaults shared with the beamformer and output-RAM instances.
package beam_peak_scanner_pkg;

    localparam int unsigned NumSamplesDflt = 540;
    localparam int unsigned AddrWDflt      = 10;
    localparam int unsigned DataWDflt      = 32;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } scan_state_e;

endpackage

// File: rtl/beam_peak_update.sv
// Registered magnitude / compare / accumulate stage: folds one tagged sample per cycle
// into the running peak and magnitude-sum working registers.
module beam_peak_update #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ACC_W  = 42
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [ADDR_W-1:0] peak_idx_o,
    output logic [DATA_W-1:0] peak_mag_o,
    output logic [ACC_W-1:0]  mag_sum_o
);

    logic [DATA_W-1:0] mag;
    logic [ADDR_W-1:0] peak_idx_q;
    logic [DATA_W-1:0] peak_mag_q;
    logic [ACC_W-1:0]  mag_sum_q;

    // Two's-complement negate in DATA_W bits: the most negative value maps to 2^(DATA_W-1).
    always_comb begin
        mag = data_i;
        if (data_i[DATA_W-1]) begin
            mag = ~data_i + DATA_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            peak_idx_q <= '0;
            peak_mag_q <= '0;
            mag_sum_q  <= '0;
        end else if (clear_i) begin
            peak_idx_q <= '0;
            peak_mag_q <= '0;
            mag_sum_q  <= '0;
        end else if (valid_i) begin
            mag_sum_q <= mag_sum_q + ACC_W'(mag);
            // Strictly greater keeps the lowest index on ties.
            if (mag > peak_mag_q) begin
                peak_idx_q <= addr_i;
                peak_mag_q <= mag;
            end
        end
    end

    assign peak_idx_o = peak_idx_q;
    assign peak_mag_o = peak_mag_q;
    assign mag_sum_o  = mag_sum_q;

endmodule

// File: rtl/beam_peak_scanner.sv
// Scans one beamformer output frame from RAM after each beamformdone rising edge and
// reports the peak-magnitude address, its magnitude and the frame magnitude sum.
module beam_peak_scanner
    import beam_peak_scanner_pkg::*;
#(
    parameter int unsigned NUM_SAMPLES  = NumSamplesDflt,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned ADDR_W       = AddrWDflt,
    parameter int unsigned DATA_W       = DataWDflt,
    parameter int unsigned ACC_W        = 42
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     beamformdone,
    output logic [ADDR_W-1:0]        rd_addr,
    output logic                     rd_en,
    input  logic signed [DATA_W-1:0] rd_data,
    output logic                     busy,
    output logic                     result_valid,
    input  logic                     result_ack,
    output logic [ADDR_W-1:0]        peak_index,
    output logic [DATA_W-1:0]        peak_mag,
    output logic [ACC_W-1:0]         mag_sum,
    output logic [15:0]              frame_count
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_SAMPLES - 1);

    scan_state_e state_q, state_d;
    logic        bfd_q, armed_q, start;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic        clear, load;
    logic        result_valid_q, result_valid_d;

    logic [READ_LATENCY-1:0]             vld_q;
    logic [READ_LATENCY:0]               vld_ext;
    logic [READ_LATENCY-1:0][ADDR_W-1:0] tag_q;
    logic [READ_LATENCY:0][ADDR_W-1:0]   tag_ext;

    logic [ADDR_W-1:0] wk_idx, peak_index_q;
    logic [DATA_W-1:0] wk_mag, peak_mag_q;
    logic [ACC_W-1:0]  wk_sum, mag_sum_q;
    logic [15:0]       frame_count_q;

    // armed_q only sets once beamformdone is seen low, so a level held high across
    // reset release cannot masquerade as a fresh edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bfd_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            bfd_q <= beamformdone;
            if (!beamformdone) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign start = armed_q & beamformdone & ~bfd_q;

    // The top tap of each *_ext vector is the entry aligned with rd_data.
    assign vld_ext = {vld_q, rd_en};
    assign tag_ext = {tag_q, rd_addr_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            tag_q <= '0;
        end else begin
            vld_q <= vld_ext[READ_LATENCY-1:0];
            tag_q <= tag_ext[READ_LATENCY-1:0];
        end
    end

    always_comb begin
        state_d        = state_q;
        rd_addr_d      = rd_addr_q;
        clear          = 1'b0;
        load           = 1'b0;
        result_valid_d = result_valid_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StRead;
                    rd_addr_d = '0;
                    clear     = 1'b1;
                end
            end
            StRead: begin
                if (rd_addr_q == LastAddr) begin
                    state_d = StDrain;
                end else begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                end
            end
            StDrain: begin
                if (vld_q == '0) begin
                    state_d        = StDone;
                    load           = 1'b1;
                    result_valid_d = 1'b1;
                end
            end
            StDone: begin
                if (result_ack) begin
                    state_d        = StIdle;
                    result_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            rd_addr_q      <= '0;
            result_valid_q <= 1'b0;
            peak_index_q   <= '0;
            peak_mag_q     <= '0;
            mag_sum_q      <= '0;
            frame_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            rd_addr_q      <= rd_addr_d;
            result_valid_q <= result_valid_d;
            if (load) begin
                peak_index_q  <= wk_idx;
                peak_mag_q    <= wk_mag;
                mag_sum_q     <= wk_sum;
                frame_count_q <= frame_count_q + 16'd1;
            end
        end
    end

    beam_peak_update #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_update (
        .clk_i      (clk),
        .rst_ni     (rst),
        .clear_i    (clear),
        .valid_i    (vld_ext[READ_LATENCY]),
        .addr_i     (tag_ext[READ_LATENCY]),
        .data_i     (rd_data),
        .peak_idx_o (wk_idx),
        .peak_mag_o (wk_mag),
        .mag_sum_o  (wk_sum)
    );

    assign rd_en        = (state_q == StRead);
    assign busy         = (state_q != StIdle);
    assign rd_addr      = rd_addr_q;
    assign result_valid = result_valid_q;
    assign peak_index   = peak_index_q;
    assign peak_mag     = peak_mag_q;
    assign mag_sum      = mag_sum_q;
    assign frame_count  = frame_count_q;

endmodule
